// File: rtl/mole_pkg.sv
// -----------------------------------------------------------------------------
// mole_pkg
// Shared types and constants for the whack-a-mole controller.
//   state_t    : controller FSM states (IDLE, GAP, SHOW)
//   LFSR_SEED  : non-zero reset value of the hole-selection LFSR
//   LFSR_TAPS  : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   lfsr_next  : one Fibonacci shift step
// -----------------------------------------------------------------------------
package mole_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Shift left, feeding back the XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_whack_ctrl_btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns raw asynchronous push buttons into single-cycle press strobes.
// Per bit: two-flop synchroniser -> (optional debounce) -> rising-edge detect.
// A held button yields exactly one press.
// Optional feature macro: MOLE_DEBOUNCE_EN (adds a per-bit stable-level
// counter of DEBOUNCE_CYCLES cycles between synchroniser and edge detect).
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   btn    in   [N-1:0] raw buttons, asynchronous, active-high
//   press  out  [N-1:0] one-cycle rising-edge strobes
// -----------------------------------------------------------------------------
module btn_conditioner
  import mole_pkg::*;
#(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn,
  output logic [N-1:0] press
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [N-1:0] sync1;
  logic [N-1:0] sync2;
  logic [N-1:0] level;
  logic [N-1:0] prev;

  // NOTE: non-blocking assignments let sync2 take the old sync1, forming a
  // real two-stage chain; blocking here would collapse it into one flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef MOLE_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     deb;

  // The debounced level only follows sync2 after it has differed from it for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  // NOTE: this counter array is reset explicitly because a stale count would
  // let a bounce be accepted early after reset; plain data RAMs need no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign level = deb;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev <= '0;
    else     prev <= level;
  end

  assign press = level & ~prev;

endmodule

// File: rtl/mole_whack_ctrl.sv
// -----------------------------------------------------------------------------
// mole_whack_ctrl
// Whack-a-mole controller: while the game is active (game_count == 0) it
// alternates a GAP period with a SHOW period in which one pseudo-randomly
// chosen hole is lit. A press on the lit hole emits `whacked`; letting the
// SHOW period expire emits `missed`. All outputs are registered.
// Optional feature macro: MOLE_DEBOUNCE_EN (button debounce, see
// btn_conditioner); the default build has no debounce.
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   game_count  in   [7:0] countdown count; game active iff zero
//   btn         in   [NUM_HOLES-1:0] raw push buttons
//   mole        out  [NUM_HOLES-1:0] one-hot lit hole, zero when none
//   whacked     out  one-cycle pulse on a correct hit
//   missed      out  one-cycle pulse when a mole times out unhit
// -----------------------------------------------------------------------------
module mole_whack_ctrl
  import mole_pkg::*;
#(
  parameter int NUM_HOLES       = 4,
  parameter int SHOW_CYCLES     = 50000000,
  parameter int GAP_CYCLES      = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           game_count,
  input  logic [NUM_HOLES-1:0] btn,
  output logic [NUM_HOLES-1:0] mole,
  output logic                 whacked,
  output logic                 missed
);

  if (NUM_HOLES < 2 || NUM_HOLES > 8 || (NUM_HOLES & (NUM_HOLES - 1)) != 0) begin : g_bad_holes
    $error("mole_whack_ctrl: NUM_HOLES must be a power of 2 in 2..8");
  end

  localparam int HOLE_W     = $clog2(NUM_HOLES);
  localparam int MAX_CYCLES = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SHOW_LOAD = TIMER_W'(SHOW_CYCLES - 1);

  state_t               state;
  logic [TIMER_W-1:0]   timer;
  logic [7:0]           lfsr;
  logic [NUM_HOLES-1:0] press;
  logic                 game_active;

  assign game_active = (game_count == 8'd0);

  btn_conditioner #(
    .N               (NUM_HOLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      timer   <= '0;
      lfsr    <= LFSR_SEED;
      mole    <= '0;
      whacked <= 1'b0;
      missed  <= 1'b0;
    end else begin
      // The LFSR free-runs so the chosen hole depends on when the mole spawns.
      lfsr    <= lfsr_next(lfsr);
      whacked <= 1'b0;
      missed  <= 1'b0;

      case (state)
        IDLE: begin
          mole  <= '0;
          timer <= '0;
          if (game_active) begin
            state <= GAP;
            timer <= GAP_LOAD;
          end
        end

        GAP: begin
          if (!game_active) begin
            state <= IDLE;
            mole  <= '0;
            timer <= '0;
          end else if (timer == '0) begin
            state <= SHOW;
            mole  <= NUM_HOLES'(1) << lfsr[HOLE_W-1:0];
            timer <= SHOW_LOAD;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        SHOW: begin
          // Priority: game stop, then hit, then timeout. Masking press with
          // the one-hot mole ignores presses on unlit holes.
          if (!game_active) begin
            state <= IDLE;
            mole  <= '0;
            timer <= '0;
          end else if ((press & mole) != '0) begin
            whacked <= 1'b1;
            mole    <= '0;
            state   <= GAP;
            timer   <= GAP_LOAD;
          end else if (timer == '0) begin
            missed <= 1'b1;
            mole   <= '0;
            state  <= GAP;
            timer  <= GAP_LOAD;
          end else begin
            timer <= timer - TIMER_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          mole  <= '0;
          timer <= '0;
        end
      endcase
    end
  end

endmodule
